pl_irq_ctrl: RTL and testbench
==============================

Name: pl_irq_ctrl

Overview:
- Interrupt aggregator between the PL timer trigger outputs and the PS IRQ_F2P input.
- Detects rising edges on up to N_SRC trigger lines.
- Latches each edge into a pending bit, masks with an enable register, and drives one registered level interrupt to the PS.
- Software services it through a simple single-cycle register port: status W1C, enable, missed-event counters, raw levels.

Parameters:
- N_SRC, 4, number of trigger sources (1..4).
- MISS_WID, 8, width of each per-source missed-event counter (N_SRC*MISS_WID <= 32).

Ports:
- clk  in  1  system clock.
- nrst  in  1  reset: synchronous, active-low, sampled on posedge clk.
- trig_in  in  N_SRC  trigger levels; same clock domain, no synchronizer.
- wr_en  in  1  register write strobe, one cycle per write.
- wr_addr  in  2  write register index.
- wr_data  in  32  write data.
- rd_addr  in  2  read register index.
- rd_data  out  32  read data, registered.
- irq_out  out  1  level interrupt to PS, registered.

Behaviour:
- Reset (nrst=0 at posedge):
  - pending=0, enable=0, all miss counters=0, trig_prev=0.
  - rd_data=0, irq_out=0.
  - Reset mid-operation discards all state the same way; it overrides any concurrent write or edge.
- Edge detect:
  - edge[i] = trig_in[i] & ~trig_prev[i].
  - trig_prev <= trig_in every cycle.
  - A line high on the first cycle after reset release counts as an edge.
  - A line held high produces exactly one edge. Multi-cycle pulses count once.
- Pending:
  - If edge[i] is detected at edge k, pending[i]=1 is visible after edge k.
  - Edges latch into pending regardless of enable; enable masks only irq_out.
- Miss counter:
  - If edge[i] occurs while pending[i] is already 1 and no clear is happening that cycle, miss[i] += 1.
  - miss[i] saturates at 2^MISS_WID-1; no wrap.
- irq_out:
  - Registered as irq_out <= |(pending & enable), using the pending/enable values after the current cycle's update.
  - Edge-to-irq latency is therefore 2 clocks from the trig_in rise: pending set at edge k, irq_out high after edge k+1.
- Register map, writes take effect at the posedge where wr_en=1:
  - 0 STATUS: read = pending, zero-extended. Write = W1C on bits [N_SRC-1:0].
  - 1 ENABLE: read/write on bits [N_SRC-1:0]; upper bits read 0.
  - 2 MISS: read = {miss[N_SRC-1],...,miss[0]}, zero-extended. Any write clears all counters.
  - 3 RAW: read = trig_in, zero-extended (current level, sampled at the read posedge). Writes ignored.
- Read timing: rd_data <= reg[rd_addr] each cycle, so 1-cycle latency.
- Simultaneous events:
  - Edge and W1C on the same bit in the same cycle: set wins, pending stays 1, miss not incremented.
  - Edge during a MISS-clear write: the counter clears, and the increment is dropped.
  - Read and write to the same register in the same cycle: rd_data returns the pre-write value.
- Deassertion: irq_out falls one clock after the W1C or enable-clear that empties (pending & enable).

Decomposition:
- Shared package pl_irq_pkg:
  - Register index constants REG_STATUS=0, REG_ENABLE=1, REG_MISS=2, REG_RAW=3.
  - Constant DATA_WID=32.
- One sub-module, pl_irq_src: per-source edge detect, pending bit and saturating miss counter, instantiated N_SRC times via generate.
- The top holds enable, the register decode and the irq_out register.

Test Plan:
- Reset, then trig_in[0] 0→1 (held 10 cycles, pltimer-style stretched pulse), ENABLE=0x1 → STATUS reads 0x1; irq_out high exactly 2 clocks after the rise; MISS=0 (one edge only).
- Write STATUS=0x1 → irq_out low one clock later. Next pulse on trig_in[0] → irq_out re-asserts.
- ENABLE=0, three pulses on trig_in[1] without clearing → irq_out stays 0; STATUS=0x2; MISS=0x0000_0200 (miss[1]=2). Write MISS → reads 0.
- 300 pulses on trig_in[2] with pending[2] set, no clear → miss[2] saturates at 0xFF; MISS=0x00FF_0000.
- Edge on trig_in[3] in the same cycle as W1C 0x8 → STATUS bit3 stays 1; miss[3] unchanged.
- nrst=0 for 1 cycle while irq_out=1 and the counters are nonzero → next cycle all reads return 0 and irq_out=0. trig_in[0] held high across reset release → pending[0]=1 after the first post-reset edge.

Source files
------------

// File: rtl/pl_irq_pkg.sv
// Shared constants for the PL interrupt aggregator.
// Register indices and data-bus width.
package pl_irq_pkg;

    localparam int DATA_WID = 32;

    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_ENABLE = 2'd1;
    localparam logic [1:0] REG_MISS   = 2'd2;
    localparam logic [1:0] REG_RAW    = 2'd3;

endpackage

// File: rtl/pl_irq_ctrl_if.sv
// Single-cycle register port of the interrupt aggregator.
// Software side is master, the aggregator is slave.
interface pl_irq_ctrl_if;
    import pl_irq_pkg::*;

    logic                wr_en;
    logic [1:0]          wr_addr;
    logic [DATA_WID-1:0] wr_data;
    logic [1:0]          rd_addr;
    logic [DATA_WID-1:0] rd_data;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        output rd_addr,
        input  rd_data
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  rd_addr,
        output rd_data
    );

endinterface

// File: rtl/pl_irq_src.sv
// One trigger source: rising-edge detect, sticky pending bit
// and a saturating counter of edges that hit an already-pending bit.
module pl_irq_src #(
    parameter int MISS_WID = 8
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                trig_i,
    input  logic                clr_i,
    input  logic                miss_clr_i,
    output logic                pend_o,
    output logic [MISS_WID-1:0] miss_o
);

    logic                prev_q;
    logic                pend_q;
    logic                pend_d;
    logic [MISS_WID-1:0] miss_q;
    logic [MISS_WID-1:0] miss_d;
    logic                rise;
    logic                sat;

    assign rise = trig_i & ~prev_q;
    assign sat  = &miss_q;

    // Pending: a new edge beats a concurrent W1C.
    always_comb begin
        pend_d = pend_q;
        if (clr_i) begin
            pend_d = 1'b0;
        end
        if (rise) begin
            pend_d = 1'b1;
        end
    end

    // Miss count: clear beats increment; W1C of this bit suppresses it.
    always_comb begin
        miss_d = miss_q;
        if (miss_clr_i) begin
            miss_d = '0;
        end else if (rise && pend_q && !clr_i && !sat) begin
            miss_d = miss_q + MISS_WID'(1);
        end
    end

    // Source state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            prev_q <= 1'b0;
            pend_q <= 1'b0;
            miss_q <= '0;
        end else begin
            prev_q <= trig_i;
            pend_q <= pend_d;
            miss_q <= miss_d;
        end
    end

    assign pend_o = pend_q;
    assign miss_o = miss_q;

endmodule

// File: rtl/pl_irq_ctrl.sv
// Aggregates PL trigger edges into one registered level IRQ
// for the PS, with a small status/enable/miss/raw register port.
module pl_irq_ctrl
    import pl_irq_pkg::*;
#(
    parameter int N_SRC    = 4,
    parameter int MISS_WID = 8
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [N_SRC-1:0] trig_in,
    pl_irq_ctrl_if.slave     bus,
    output logic             irq_out
);

    localparam int MISS_ALL = N_SRC * MISS_WID;

    logic                wr_status;
    logic                wr_enable;
    logic                wr_miss;
    logic [N_SRC-1:0]    clr;
    logic [N_SRC-1:0]    pend;
    logic [MISS_ALL-1:0] miss_cat;
    logic [N_SRC-1:0]    en_q;
    logic [N_SRC-1:0]    en_d;
    logic [DATA_WID-1:0] rd_q;
    logic [DATA_WID-1:0] rd_d;
    logic                irq_q;
    logic                unused_wdata;

    assign wr_status = bus.wr_en && (bus.wr_addr == REG_STATUS);
    assign wr_enable = bus.wr_en && (bus.wr_addr == REG_ENABLE);
    assign wr_miss   = bus.wr_en && (bus.wr_addr == REG_MISS);

    assign clr = wr_status ? bus.wr_data[N_SRC-1:0] : '0;

    assign unused_wdata = ^bus.wr_data[DATA_WID-1:N_SRC];

    for (genvar g = 0; g < N_SRC; g++) begin : g_src
        pl_irq_src #(
            .MISS_WID (MISS_WID)
        ) u_src (
            .clk        (clk),
            .nrst       (nrst),
            .trig_i     (trig_in[g]),
            .clr_i      (clr[g]),
            .miss_clr_i (wr_miss),
            .pend_o     (pend[g]),
            .miss_o     (miss_cat[g*MISS_WID +: MISS_WID])
        );
    end

    // Enable register next state.
    always_comb begin
        en_d = en_q;
        if (wr_enable) begin
            en_d = bus.wr_data[N_SRC-1:0];
        end
    end

    // Read mux over pre-write state; RAW shows the live trigger level.
    always_comb begin
        rd_d = '0;
        case (bus.rd_addr)
            REG_STATUS: rd_d[N_SRC-1:0]    = pend;
            REG_ENABLE: rd_d[N_SRC-1:0]    = en_q;
            REG_MISS:   rd_d[MISS_ALL-1:0] = miss_cat;
            REG_RAW:    rd_d[N_SRC-1:0]    = trig_in;
            default:    rd_d               = '0;
        endcase
    end

    // Enable, read data and IRQ level; IRQ follows registered state.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            en_q  <= '0;
            rd_q  <= '0;
            irq_q <= 1'b0;
        end else begin
            en_q  <= en_d;
            rd_q  <= rd_d;
            irq_q <= |(pend & en_q);
        end
    end

    assign bus.rd_data = rd_q;
    assign irq_out     = irq_q;

endmodule

// File: tb/tb_pl_irq_ctrl.sv
// Self-checking bench for pl_irq_ctrl: a cycle table for the
// IRQ latency path plus sequences for miss/saturation/reset cases.
module tb_pl_irq_ctrl;
    import pl_irq_pkg::*;

    typedef struct {
        logic [3:0]  trig;
        logic        we;
        logic [1:0]  wa;
        logic [31:0] wd;
        logic [1:0]  ra;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    logic       clk = 1'b0;
    logic       nrst;
    logic [3:0] trig_in;
    logic       irq_out;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    vec_t        vecs[21];

    pl_irq_ctrl_if bus ();

    pl_irq_ctrl #(
        .N_SRC    (4),
        .MISS_WID (8)
    ) dut (
        .clk     (clk),
        .nrst    (nrst),
        .trig_in (trig_in),
        .bus     (bus),
        .irq_out (irq_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e,
                      input string nm);
        bus.rd_addr = a;
        exp_q.push_back(e);
        tick();
        chk(nm, bus.rd_data, exp_q.pop_front());
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic pulse(input int idx);
        trig_in[idx] = 1'b1;
        tick();
        trig_in[idx] = 1'b0;
        tick();
    endtask

    function automatic vec_t mk(logic [3:0] t, logic we, logic [1:0] wa,
                                logic [31:0] wd, logic [1:0] ra,
                                logic [31:0] er, logic ei);
        vec_t v;
        v.trig = t; v.we = we; v.wa = wa; v.wd = wd;
        v.ra = ra; v.exp_rd = er; v.exp_irq = ei;
        return v;
    endfunction

    initial begin
        vecs[0]  = mk(4'h0, 1, REG_ENABLE, 32'h1, REG_STATUS, 32'h0, 0);
        vecs[1]  = mk(4'h1, 0, REG_STATUS, 32'h0, REG_STATUS, 32'h0, 0);
        vecs[2]  = mk(4'h1, 0, REG_STATUS, 32'h0, REG_STATUS, 32'h1, 1);
        for (int i = 3; i <= 10; i++) begin
            vecs[i] = mk(4'h1, 0, REG_STATUS, 32'h0, REG_MISS, 32'h0, 1);
        end
        vecs[11] = mk(4'h0, 0, REG_STATUS, 32'h0, REG_RAW, 32'h0, 1);
        vecs[12] = mk(4'h0, 1, REG_STATUS, 32'h1, REG_STATUS, 32'h1, 1);
        vecs[13] = mk(4'h0, 0, REG_STATUS, 32'h0, REG_STATUS, 32'h0, 0);
        vecs[14] = mk(4'h1, 0, REG_STATUS, 32'h0, REG_RAW, 32'h1, 0);
        vecs[15] = mk(4'h0, 0, REG_STATUS, 32'h0, REG_STATUS, 32'h1, 1);
        vecs[16] = mk(4'h0, 0, REG_STATUS, 32'h0, REG_ENABLE, 32'h1, 1);
        vecs[17] = mk(4'h0, 1, REG_ENABLE, 32'h0, REG_ENABLE, 32'h1, 1);
        vecs[18] = mk(4'h0, 0, REG_STATUS, 32'h0, REG_ENABLE, 32'h0, 0);
        vecs[19] = mk(4'h0, 1, REG_STATUS, 32'hF, REG_STATUS, 32'h1, 0);
        vecs[20] = mk(4'h0, 0, REG_STATUS, 32'h0, REG_STATUS, 32'h0, 0);

        nrst        = 1'b0;
        trig_in     = 4'h0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = 2'd0;
        bus.wr_data = 32'h0;
        bus.rd_addr = REG_STATUS;
        tick();
        tick();
        chk("reset_rd_data", bus.rd_data, 32'h0);
        chk("reset_irq", {31'h0, irq_out}, 32'h0);
        nrst = 1'b1;

        for (int i = 0; i < 21; i++) begin
            trig_in     = vecs[i].trig;
            bus.wr_en   = vecs[i].we;
            bus.wr_addr = vecs[i].wa;
            bus.wr_data = vecs[i].wd;
            bus.rd_addr = vecs[i].ra;
            exp_q.push_back(vecs[i].exp_rd);
            tick();
            chk($sformatf("vec%0d_rd", i), bus.rd_data, exp_q.pop_front());
            chk($sformatf("vec%0d_irq", i), {31'h0, irq_out},
                {31'h0, vecs[i].exp_irq});
        end
        bus.wr_en = 1'b0;
        trig_in   = 4'h0;

        for (int i = 0; i < 3; i++) pulse(1);
        chk("masked_irq", {31'h0, irq_out}, 32'h0);
        rd(REG_STATUS, 32'h2, "status_src1");
        rd(REG_MISS, 32'h0000_0200, "miss_src1");
        wr(REG_MISS, 32'h0);
        rd(REG_MISS, 32'h0, "miss_cleared");
        rd(REG_STATUS, 32'h2, "status_after_missclr");

        for (int i = 0; i < 300; i++) pulse(2);
        rd(REG_MISS, 32'h00FF_0000, "miss_saturate");
        rd(REG_STATUS, 32'h6, "status_src2");

        trig_in[2] = 1'b1;
        wr(REG_MISS, 32'h0);
        trig_in[2] = 1'b0;
        rd(REG_MISS, 32'h0, "edge_during_missclr");

        pulse(3);
        rd(REG_STATUS, 32'hE, "status_src3");
        trig_in[3] = 1'b1;
        wr(REG_STATUS, 32'h8);
        trig_in[3] = 1'b0;
        rd(REG_STATUS, 32'hE, "edge_beats_w1c");
        rd(REG_MISS, 32'h0, "w1c_no_miss");

        wr(REG_ENABLE, 32'hF);
        tick();
        chk("irq_enabled", {31'h0, irq_out}, 32'h1);
        pulse(1);
        pulse(1);
        rd(REG_MISS, 32'h0000_0200, "miss_before_reset");

        trig_in[0]  = 1'b1;
        nrst        = 1'b0;
        bus.wr_en   = 1'b1;
        bus.wr_addr = REG_ENABLE;
        bus.wr_data = 32'hF;
        bus.rd_addr = REG_STATUS;
        tick();
        nrst      = 1'b1;
        bus.wr_en = 1'b0;
        chk("midreset_irq", {31'h0, irq_out}, 32'h0);
        chk("midreset_rd", bus.rd_data, 32'h0);
        rd(REG_STATUS, 32'h0, "post_reset_status0");
        rd(REG_STATUS, 32'h1, "held_high_edge");
        rd(REG_ENABLE, 32'h0, "enable_after_reset");
        rd(REG_MISS, 32'h0, "miss_after_reset");
        chk("irq_after_reset", {31'h0, irq_out}, 32'h0);
        trig_in[0] = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
